// File: rtl/address_entry.sv
// rtl/address_entry.sv - keypad scan, debounce and BCD-to-binary address entry
//
// Purpose: scans a 4x4 active-low matrix keypad, debounces presses and releases,
// accumulates up to three BCD digits and commits them as a 9-bit binary address.
// Optional macro: ADDRESS_AUTO_COMMIT_EN - the digit that makes the entry three
// digits long also triggers an implicit ENTER on the following clock.
//
// Ports:
//   clk           in   system clock, posedge
//   reset         in   synchronous active-low reset
//   key_cols[3:0] in   column sense, active-low, already synchronised
//   key_rows[3:0] out  row drive, one-hot active-low
//   address_line  out  last committed address (9 bits)
//   address_valid out  one-clock strobe when address_line is updated
//   entry_bcd     out  pending digits {hundreds, tens, ones}
//   entry_count   out  number of pending digits, 0..3
//   overflow      out  sticky: last ENTER exceeded MAX_ADDRESS
module address_entry #(
   parameter int SCAN_DIV        = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_ADDRESS     = 511
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  key_cols,
   output logic [3:0]  key_rows,
   output logic [8:0]  address_line,
   output logic        address_valid,
   output logic [11:0] entry_bcd,
   output logic [1:0]  entry_count,
   output logic        overflow
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES);
   localparam logic [9:0]       MAX_VAL  = 10'(MAX_ADDRESS);

   typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_RELEASE} state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_row_idx, w_row_nxt;
   logic [DIV_W-1:0] r_div, w_div_nxt;
   logic [DEB_W-1:0] r_deb_cnt, w_deb_nxt;
   logic [3:0]       r_pattern, w_pat_nxt;
   logic             w_fire;

   logic [11:0] r_bcd, w_bcd_nxt;
   logic [1:0]  r_count, w_count_nxt;
   logic [8:0]  r_addr, w_addr_nxt;
   logic        r_valid, w_valid_nxt;
   logic        r_ovf, w_ovf_nxt;

   logic [1:0]  w_col_idx;
   logic [3:0]  w_code;
   logic [9:0]  w_value;
   logic        w_auto_enter;
   logic        w_do_enter;

   // Key code comes from the latched pattern so it is stable for the whole debounce.
   always_comb begin
      w_col_idx = 2'd0;
      if (!r_pattern[0])      w_col_idx = 2'd0;
      else if (!r_pattern[1]) w_col_idx = 2'd1;
      else if (!r_pattern[2]) w_col_idx = 2'd2;
      else                    w_col_idx = 2'd3;
   end

   assign w_code  = {r_row_idx, w_col_idx};
   assign w_value = {6'd0, r_bcd[11:8]} * 10'd100
                  + {6'd0, r_bcd[7:4]}  * 10'd10
                  + {6'd0, r_bcd[3:0]};

   // Scan / debounce / release sequencing.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row_idx;
      w_div_nxt   = r_div;
      w_deb_nxt   = r_deb_cnt;
      w_pat_nxt   = r_pattern;
      w_fire      = 1'b0;
      case (r_state)
         ST_SCAN: begin
            if (r_div == DIV_LAST) begin
               w_div_nxt = '0;
               if (key_cols == 4'hF) begin
                  w_row_nxt = r_row_idx + 2'd1;
               end else begin
                  w_pat_nxt   = key_cols;
                  w_deb_nxt   = '0;
                  w_state_nxt = ST_DEBOUNCE;
               end
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (key_cols == r_pattern) begin
               if (r_deb_cnt + 1'b1 == DEB_LAST) begin
                  w_fire      = 1'b1;
                  w_deb_nxt   = '0;
                  w_state_nxt = ST_RELEASE;
               end else begin
                  w_deb_nxt = r_deb_cnt + 1'b1;
               end
            end else begin
               w_deb_nxt   = '0;
               w_div_nxt   = '0;
               w_row_nxt   = r_row_idx + 2'd1;
               w_state_nxt = ST_SCAN;
            end
         end
         ST_RELEASE: begin
            if (key_cols == 4'hF) begin
               if (r_deb_cnt + 1'b1 == DEB_LAST) begin
                  w_deb_nxt   = '0;
                  w_div_nxt   = '0;
                  w_row_nxt   = r_row_idx + 2'd1;
                  w_state_nxt = ST_SCAN;
               end else begin
                  w_deb_nxt = r_deb_cnt + 1'b1;
               end
            end else begin
               w_deb_nxt = '0;
            end
         end
         default: w_state_nxt = ST_SCAN;
      endcase
   end

`ifdef ADDRESS_AUTO_COMMIT_EN
   logic r_auto_pend;
   always_ff @(posedge clk) begin
      if (!reset) r_auto_pend <= 1'b0;
      else        r_auto_pend <= w_fire && (w_code <= 4'd9) && (r_count == 2'd2);
   end
   assign w_auto_enter = r_auto_pend;
`else
   assign w_auto_enter = 1'b0;
`endif

   // ENTER with an empty entry falls through to the no-action default below.
   assign w_do_enter = (w_fire && (w_code == 4'd11) && (r_count != 2'd0)) || w_auto_enter;

   always_comb begin
      w_bcd_nxt   = r_bcd;
      w_count_nxt = r_count;
      w_addr_nxt  = r_addr;
      w_valid_nxt = 1'b0;
      w_ovf_nxt   = r_ovf;
      if (w_do_enter) begin
         if (w_value <= MAX_VAL) begin
            w_addr_nxt  = w_value[8:0];
            w_valid_nxt = 1'b1;
            w_ovf_nxt   = 1'b0;
         end else begin
            w_ovf_nxt = 1'b1;
         end
         w_bcd_nxt   = '0;
         w_count_nxt = '0;
      end else if (w_fire) begin
         if (w_code <= 4'd9) begin
            w_bcd_nxt   = {r_bcd[7:0], w_code};
            w_count_nxt = (r_count == 2'd3) ? 2'd3 : r_count + 2'd1;
         end else if (w_code == 4'd10) begin
            w_bcd_nxt   = '0;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
         end else if (w_code == 4'd12) begin
            w_bcd_nxt   = {4'd0, r_bcd[11:4]};
            w_count_nxt = (r_count == 2'd0) ? 2'd0 : r_count - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_SCAN;
         r_row_idx <= '0;
         r_div     <= '0;
         r_deb_cnt <= '0;
         r_pattern <= 4'hF;
         r_bcd     <= '0;
         r_count   <= '0;
         r_addr    <= '0;
         r_valid   <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_row_idx <= w_row_nxt;
         r_div     <= w_div_nxt;
         r_deb_cnt <= w_deb_nxt;
         r_pattern <= w_pat_nxt;
         r_bcd     <= w_bcd_nxt;
         r_count   <= w_count_nxt;
         r_addr    <= w_addr_nxt;
         r_valid   <= w_valid_nxt;
         r_ovf     <= w_ovf_nxt;
      end
   end

   assign key_rows      = ~(4'b0001 << r_row_idx);
   assign address_line  = r_addr;
   assign address_valid = r_valid;
   assign entry_bcd     = r_bcd;
   assign entry_count   = r_count;
   assign overflow      = r_ovf;

endmodule

// File: tb/tb_address_entry.sv
// tb/tb_address_entry.sv - directed self-checking bench for address_entry
module tb_address_entry;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  key_cols;
   logic [3:0]  key_rows;
   logic [8:0]  address_line;
   logic        address_valid;
   logic [11:0] entry_bcd;
   logic [1:0]  entry_count;
   logic        overflow;

   logic [3:0]  key_code  = 4'd0;
   logic        key_down  = 1'b0;
   logic        force_en  = 1'b0;
   logic [3:0]  force_val = 4'hF;

   int passed = 0;
   int total  = 0;

   int   cyc = 0;
   int   vcount = 0;
   int   vconsec = 0;
   int   last_valid_cyc = -1;
   int   cnt3_cyc = -1;
   logic prev_valid = 1'b0;
   logic [1:0] prev_count = 2'd0;

   always #5 clk = ~clk;

   address_entry #(.SCAN_DIV(8), .DEBOUNCE_CYCLES(4), .MAX_ADDRESS(511)) dut (
      .clk(clk),
      .reset(reset),
      .key_cols(key_cols),
      .key_rows(key_rows),
      .address_line(address_line),
      .address_valid(address_valid),
      .entry_bcd(entry_bcd),
      .entry_count(entry_count),
      .overflow(overflow)
   );

   // Matrix keypad model: a held key pulls its column low while its row is driven.
   always_comb begin
      key_cols = 4'hF;
      if (force_en)
         key_cols = force_val;
      else if (key_down && (key_rows[key_code[3:2]] == 1'b0))
         key_cols[key_code[1:0]] = 1'b0;
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (address_valid === 1'b1) begin
         vcount = vcount + 1;
         last_valid_cyc = cyc;
         if (prev_valid === 1'b1) vconsec = vconsec + 1;
      end
      if (entry_count == 2'd3 && prev_count != 2'd3) cnt3_cyc = cyc;
      prev_valid = address_valid;
      prev_count = entry_count;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] k);
      key_code = k;
      key_down = 1'b1;
      cycles(60);
      key_down = 1'b0;
      cycles(20);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      force_en = 1'b1;
      force_val = 4'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (address_line !== 9'd0) $display("FAIL reset_addr: got %0d expected 0", address_line); else passed++;
      total++; if (address_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", address_valid); else passed++;
      total++; if (entry_bcd !== 12'h000) $display("FAIL reset_bcd: got %h expected 000", entry_bcd); else passed++;
      total++; if (entry_count !== 2'd0) $display("FAIL reset_count: got %0d expected 0", entry_count); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", overflow); else passed++;
      total++; if (key_rows !== 4'b1110) $display("FAIL reset_rows: got %b expected 1110", key_rows); else passed++;
      reset = 1'b1;
      cycles(20);
      force_val = 4'hF;
      cycles(20);
      force_en = 1'b0;
      total++; if (entry_count !== 2'd1) $display("FAIL held_key_count: got %0d expected 1", entry_count); else passed++;
      total++; if (entry_bcd !== 12'h000) $display("FAIL held_key_bcd: got %h expected 000", entry_bcd); else passed++;
   endtask

   task automatic test_commit;
      press(4'd10);
      vcount = 0;
      press(4'd2); press(4'd5); press(4'd5);
`ifndef ADDRESS_AUTO_COMMIT_EN
      total++; if (entry_bcd !== 12'h255) $display("FAIL commit_bcd: got %h expected 255", entry_bcd); else passed++;
`endif
      press(4'd11);
      total++; if (address_line !== 9'd255) $display("FAIL commit_addr: got %0d expected 255", address_line); else passed++;
      total++; if (vcount !== 1) $display("FAIL commit_strobes: got %0d expected 1", vcount); else passed++;
      total++; if (entry_count !== 2'd0) $display("FAIL commit_cleared: got %0d expected 0", entry_count); else passed++;
   endtask

   task automatic test_overflow;
      vcount = 0;
      press(4'd6); press(4'd0); press(4'd0); press(4'd11);
      total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else passed++;
      total++; if (address_line !== 9'd255) $display("FAIL ovf_addr_kept: got %0d expected 255", address_line); else passed++;
      total++; if (vcount !== 0) $display("FAIL ovf_no_strobe: got %0d expected 0", vcount); else passed++;
      total++; if (entry_count !== 2'd0) $display("FAIL ovf_cleared: got %0d expected 0", entry_count); else passed++;
   endtask

   task automatic test_bounce;
      press(4'd10);
      total++; if (overflow !== 1'b0) $display("FAIL clear_ovf: got %b expected 0", overflow); else passed++;
      key_code = 4'd7;
      for (int i = 0; i < 30; i++) begin
         key_down = 1'b1; cycles(2);
         key_down = 1'b0; cycles(2);
      end
      total++; if (entry_count !== 2'd0) $display("FAIL bounce_rejected: got %0d expected 0", entry_count); else passed++;
      press(4'd7);
      total++; if (entry_count !== 2'd1) $display("FAIL bounce_count: got %0d expected 1", entry_count); else passed++;
      total++; if (entry_bcd !== 12'h007) $display("FAIL bounce_bcd: got %h expected 007", entry_bcd); else passed++;
   endtask

   task automatic test_backspace;
      press(4'd10);
`ifndef ADDRESS_AUTO_COMMIT_EN
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      total++; if (entry_bcd !== 12'h234) $display("FAIL shift_bcd: got %h expected 234", entry_bcd); else passed++;
      total++; if (entry_count !== 2'd3) $display("FAIL shift_count: got %0d expected 3", entry_count); else passed++;
      press(4'd12);
      total++; if (entry_bcd !== 12'h023) $display("FAIL bs_bcd: got %h expected 023", entry_bcd); else passed++;
      total++; if (entry_count !== 2'd2) $display("FAIL bs_count: got %0d expected 2", entry_count); else passed++;
      vcount = 0;
      press(4'd11);
      total++; if (address_line !== 9'd23) $display("FAIL bs_addr: got %0d expected 23", address_line); else passed++;
`else
      press(4'd1); press(4'd2); press(4'd12);
      total++; if (entry_bcd !== 12'h001) $display("FAIL bs_bcd: got %h expected 001", entry_bcd); else passed++;
      total++; if (entry_count !== 2'd1) $display("FAIL bs_count: got %0d expected 1", entry_count); else passed++;
      vcount = 0;
      press(4'd11);
      total++; if (address_line !== 9'd1) $display("FAIL bs_addr: got %0d expected 1", address_line); else passed++;
`endif
      total++; if (vcount !== 1) $display("FAIL bs_strobes: got %0d expected 1", vcount); else passed++;
   endtask

   task automatic test_empty;
      logic [8:0] exp_addr;
`ifndef ADDRESS_AUTO_COMMIT_EN
      exp_addr = 9'd23;
`else
      exp_addr = 9'd1;
`endif
      press(4'd12);
      total++; if (entry_count !== 2'd0) $display("FAIL bs_empty: got %0d expected 0", entry_count); else passed++;
      press(4'd13);
      total++; if (entry_bcd !== 12'h000) $display("FAIL noop_key: got %h expected 000", entry_bcd); else passed++;
      vcount = 0;
      press(4'd11);
      total++; if (vcount !== 0) $display("FAIL empty_enter_strobe: got %0d expected 0", vcount); else passed++;
      total++; if (address_line !== exp_addr) $display("FAIL empty_enter_addr: got %0d expected %0d", address_line, exp_addr); else passed++;
   endtask

   task automatic test_auto_commit;
      press(4'd10);
      vcount = 0;
      press(4'd4); press(4'd0); press(4'd9);
`ifdef ADDRESS_AUTO_COMMIT_EN
      total++; if (address_line !== 9'd409) $display("FAIL auto_addr: got %0d expected 409", address_line); else passed++;
      total++; if (vcount !== 1) $display("FAIL auto_strobes: got %0d expected 1", vcount); else passed++;
      total++; if (last_valid_cyc - cnt3_cyc !== 1) $display("FAIL auto_latency: got %0d expected 1", last_valid_cyc - cnt3_cyc); else passed++;
      total++; if (entry_count !== 2'd0) $display("FAIL auto_cleared: got %0d expected 0", entry_count); else passed++;
`else
      total++; if (entry_bcd !== 12'h409) $display("FAIL no_auto_bcd: got %h expected 409", entry_bcd); else passed++;
      total++; if (vcount !== 0) $display("FAIL no_auto_strobe: got %0d expected 0", vcount); else passed++;
`endif
      total++; if (vconsec !== 0) $display("FAIL strobe_consecutive: got %0d expected 0", vconsec); else passed++;
   endtask

   initial begin
      test_reset;
      test_commit;
      test_overflow;
      test_bounce;
      test_backspace;
      test_empty;
      test_auto_commit;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
